core_controller: RTL and testbench

CORE_CONTROLLER -- requirements
Module: core_controller

---
 rtl/core_controller_pkg.sv | 110 +++++++++++
 rtl/core_controller_if.sv | 41 ++++
 rtl/core_decode.sv | 39 +++
 rtl/core_controller.sv | 168 ++++++++++++++++
 tb/tb_core_controller.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_controller_pkg.sv
// Shared encodings for the multi-cycle core controller: FSM states, ALU codes,
// instruction field constants, datapath mux selects and the control word.
package core_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_EXEC_SH,
    S_MEM_LD,
    S_MEM_ST,
    S_BRANCH,
    S_WB
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_PASSB = 4'd5,
    ALU_CMP   = 4'd6
  } alu_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_SH,
    CLS_LD,
    CLS_ST,
    CLS_BR,
    CLS_ILL
  } class_e;

  localparam logic [3:0] OP_RTYPE    = 4'b0000;
  localparam logic [3:0] OP_MEM      = 4'b0100;
  localparam logic [3:0] OP_SHIFT    = 4'b1000;
  localparam logic [3:0] OP_BRANCH   = 4'b1100;
  localparam logic [3:0] OPEXT_LOAD  = 4'b0000;
  localparam logic [3:0] OPEXT_STORE = 4'b0100;

  // ALU operation codes; shared by opext (register form) and op (immediate form)
  localparam logic [3:0] CODE_ADD   = 4'b0101;
  localparam logic [3:0] CODE_SUB   = 4'b1001;
  localparam logic [3:0] CODE_CMP   = 4'b1011;
  localparam logic [3:0] CODE_AND   = 4'b0001;
  localparam logic [3:0] CODE_OR    = 4'b0010;
  localparam logic [3:0] CODE_XOR   = 4'b0011;
  localparam logic [3:0] CODE_PASSB = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] B_REG     = 2'd0;
  localparam logic [1:0] B_SIGN    = 2'd1;
  localparam logic [1:0] B_ONE     = 2'd2;
  localparam logic [1:0] B_ZERO    = 2'd3;
  localparam logic [1:0] WB_RESULT = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;

  // flags are packed {C,L,F,Z,N}
  localparam int FLAG_Z = 1;

  typedef struct packed {
    logic ok;
    alu_e op;
  } alu_sel_t;

  function automatic alu_sel_t alu_lookup(input logic [3:0] code);
    alu_sel_t sel;
    sel.ok = 1'b1;
    sel.op = ALU_ADD;
    case (code)
      CODE_ADD:   sel.op = ALU_ADD;
      CODE_SUB:   sel.op = ALU_SUB;
      CODE_CMP:   sel.op = ALU_CMP;
      CODE_AND:   sel.op = ALU_AND;
      CODE_OR:    sel.op = ALU_OR;
      CODE_XOR:   sel.op = ALU_XOR;
      CODE_PASSB: sel.op = ALU_PASSB;
      default:    sel.ok = 1'b0;
    endcase
    return sel;
  endfunction

  typedef struct packed {
    logic       irEn;
    logic       pcRegEn;
    logic       srcRegEn;
    logic       dstRegEn;
    logic       immRegEn;
    logic       resultRegEn;
    logic       signEn;
    logic       regFileEn;
    logic       pcRegMuxEn;
    logic       shiftALUMuxEn;
    logic       regImmMuxEn;
    logic [1:0] mux4En;
    logic [1:0] regFileResultCont;
    alu_e       aluControl;
    logic       memRead;
    logic       memWrite;
    logic       instrDone;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/core_controller_if.sv
// Controller <-> datapath bundle: instruction/flags/memory ack in, control strobes out.
interface core_controller_if;
  logic [15:0] instruction;
  logic [4:0]  flags;
  logic        memReady;

  logic        irEn;
  logic        pcRegEn;
  logic        srcRegEn;
  logic        dstRegEn;
  logic        immRegEn;
  logic        resultRegEn;
  logic        signEn;
  logic        regFileEn;
  logic        pcRegMuxEn;
  logic        shiftALUMuxEn;
  logic        regImmMuxEn;
  logic [1:0]  mux4En;
  logic [1:0]  regFileResultCont;
  logic [3:0]  aluControl;
  logic        memRead;
  logic        memWrite;
  logic        instrDone;
  logic        illegal;

  modport master (
    input  instruction, flags, memReady,
    output irEn, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn,
    output signEn, regFileEn, pcRegMuxEn, shiftALUMuxEn, regImmMuxEn,
    output mux4En, regFileResultCont, aluControl,
    output memRead, memWrite, instrDone, illegal
  );

  modport slave (
    output instruction, flags, memReady,
    input  irEn, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn,
    input  signEn, regFileEn, pcRegMuxEn, shiftALUMuxEn, regImmMuxEn,
    input  mux4En, regFileResultCont, aluControl,
    input  memRead, memWrite, instrDone, illegal
  );
endinterface

// File: rtl/core_decode.sv
// Combinational instruction classifier: op/opext -> instruction class and ALU ops.
module core_decode
  import core_controller_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] opext,
  output class_e     cls,
  output alu_e       alu_r,
  output logic       alu_r_ok,
  output alu_e       alu_i
);

  alu_sel_t sel_r;
  alu_sel_t sel_i;

  always_comb begin
    sel_r    = alu_lookup(opext);
    sel_i    = alu_lookup(op);
    alu_r    = sel_r.op;
    alu_r_ok = sel_r.ok;
    alu_i    = sel_i.op;
    cls      = CLS_ILL;
    case (op)
      OP_RTYPE:  cls = CLS_R;
      OP_MEM: begin
        if (opext == OPEXT_LOAD) begin
          cls = CLS_LD;
        end else if (opext == OPEXT_STORE) begin
          cls = CLS_ST;
        end
      end
      OP_SHIFT:  cls = CLS_SH;
      OP_BRANCH: cls = CLS_BR;
      // every remaining op that names an ALU operation is its immediate form
      default:   if (sel_i.ok) cls = CLS_I;
    endcase
  end

endmodule

// File: rtl/core_controller.sv
// Multi-cycle core control FSM; outputs are decoded from the state (plus memReady,
// flags and instruction where a state's action depends on them) and forced low in reset.
module core_controller
  import core_controller_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  core_controller_if.master bus
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  class_e cls;
  alu_e   alu_r;
  alu_e   alu_i;
  alu_e   exec_alu;
  logic   alu_r_ok;
  logic   exec_ok;
  logic   is_imm;
  logic   branch_taken;
  logic   unused_bits;

  core_decode u_decode (
    .op       (bus.instruction[15:12]),
    .opext    (bus.instruction[7:4]),
    .cls      (cls),
    .alu_r    (alu_r),
    .alu_r_ok (alu_r_ok),
    .alu_i    (alu_i)
  );

  // Rsrc and the non-Z flags are consumed by the datapath, not here
  assign unused_bits = ^{bus.instruction[3:0], bus.flags[4:2], bus.flags[0]};

  assign is_imm   = (state_q == S_EXEC_I);
  assign exec_alu = is_imm ? alu_i : alu_r;
  assign exec_ok  = is_imm | alu_r_ok;

  always_comb begin
    branch_taken = 1'b0;
    case (bus.instruction[11:8])
      COND_EQ: branch_taken = bus.flags[FLAG_Z];
      COND_NE: branch_taken = ~bus.flags[FLAG_Z];
      COND_AL: branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl.irEn       = 1'b1;
        ctrl.pcRegEn    = 1'b1;
        ctrl.mux4En     = B_ONE;
        ctrl.aluControl = ALU_ADD;
        state_d         = S_DECODE;
      end
      S_DECODE: begin
        ctrl.srcRegEn = 1'b1;
        ctrl.dstRegEn = 1'b1;
        ctrl.immRegEn = 1'b1;
        ctrl.signEn   = 1'b1;
        case (cls)
          CLS_R:   state_d = S_EXEC_R;
          CLS_I:   state_d = S_EXEC_I;
          CLS_SH:  state_d = S_EXEC_SH;
          CLS_LD:  state_d = S_MEM_LD;
          CLS_ST:  state_d = S_MEM_ST;
          CLS_BR:  state_d = S_BRANCH;
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        ctrl.pcRegMuxEn  = 1'b1;
        ctrl.resultRegEn = 1'b1;
        ctrl.mux4En      = is_imm ? B_SIGN : B_REG;
        if (exec_ok) begin
          ctrl.aluControl = exec_alu;
          // compare only updates flags, so it retires without a write-back
          if (exec_alu == ALU_CMP) begin
            ctrl.instrDone = 1'b1;
            state_d        = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          ctrl.illegal = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXEC_SH: begin
        ctrl.shiftALUMuxEn = 1'b1;
        ctrl.resultRegEn   = 1'b1;
        ctrl.regImmMuxEn   = ~bus.instruction[6];
        state_d            = S_WB;
      end
      S_MEM_LD: begin
        ctrl.memRead = 1'b1;
        if (bus.memReady) begin
          ctrl.regFileEn         = 1'b1;
          ctrl.regFileResultCont = WB_MEM;
          ctrl.instrDone         = 1'b1;
          state_d                = S_FETCH;
        end
      end
      S_MEM_ST: begin
        ctrl.memWrite = 1'b1;
        if (bus.memReady) begin
          ctrl.instrDone = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_BRANCH: begin
        if (branch_taken) begin
          ctrl.mux4En     = B_SIGN;
          ctrl.aluControl = ALU_ADD;
          ctrl.pcRegEn    = 1'b1;
        end
        ctrl.instrDone = 1'b1;
        state_d        = S_FETCH;
      end
      S_WB: begin
        ctrl.regFileEn         = 1'b1;
        ctrl.regFileResultCont = WB_RESULT;
        ctrl.instrDone         = 1'b1;
        state_d                = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      ctrl = '0;
    end
  end

  assign bus.irEn              = ctrl.irEn;
  assign bus.pcRegEn           = ctrl.pcRegEn;
  assign bus.srcRegEn          = ctrl.srcRegEn;
  assign bus.dstRegEn          = ctrl.dstRegEn;
  assign bus.immRegEn          = ctrl.immRegEn;
  assign bus.resultRegEn       = ctrl.resultRegEn;
  assign bus.signEn            = ctrl.signEn;
  assign bus.regFileEn         = ctrl.regFileEn;
  assign bus.pcRegMuxEn        = ctrl.pcRegMuxEn;
  assign bus.shiftALUMuxEn     = ctrl.shiftALUMuxEn;
  assign bus.regImmMuxEn       = ctrl.regImmMuxEn;
  assign bus.mux4En            = ctrl.mux4En;
  assign bus.regFileResultCont = ctrl.regFileResultCont;
  assign bus.aluControl        = ctrl.aluControl;
  assign bus.memRead           = ctrl.memRead;
  assign bus.memWrite          = ctrl.memWrite;
  assign bus.instrDone         = ctrl.instrDone;
  assign bus.illegal           = ctrl.illegal;

endmodule

// File: tb/tb_core_controller.sv
// Scoreboard bench for core_controller: a per-instruction behaviour model predicts a
// summary record at issue time; a monitor rebuilds that record from the DUT's strobes.
module tb_core_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_controller_if bus ();

  core_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] cycles;
    logic       illegal;
    logic [1:0] reg_wr;
    logic [1:0] wb_sel;
    logic [7:0] rd;
    logic [7:0] wr;
    logic [1:0] pc;
    logic [1:0] pc_mux;
    logic [3:0] alu;
    logic [1:0] mux;
    logic       shift;
    logic       regimm;
    logic [1:0] dec;
  } rec_t;

  typedef struct packed {
    logic [15:0] instr;
    rec_t        rec;
  } txn_t;

  txn_t       exp_q[$];
  int         checks    = 0;
  int         passes    = 0;
  int         waits_cur = 0;
  int         txn_n     = 0;
  int         alu_of[int];
  logic [3:0] codes[7]  = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
  logic [3:0] conds[4]  = '{4'h0, 4'h1, 4'hE, 4'h7};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic logic [22:0] outs();
    return {bus.irEn, bus.pcRegEn, bus.srcRegEn, bus.dstRegEn, bus.immRegEn,
            bus.resultRegEn, bus.signEn, bus.regFileEn, bus.pcRegMuxEn,
            bus.shiftALUMuxEn, bus.regImmMuxEn, bus.mux4En, bus.regFileResultCont,
            bus.aluControl, bus.memRead, bus.memWrite, bus.instrDone, bus.illegal};
  endfunction

  // Instruction-level behaviour: what one instruction should do from FETCH to retirement.
  function automatic rec_t model(input logic [15:0] instr, input logic [4:0] fl, input int waits);
    rec_t       e;
    logic [3:0] op;
    logic [3:0] cond;
    logic [3:0] ox;
    int         a;
    bit         taken;
    op   = instr[15:12];
    cond = instr[11:8];
    ox   = instr[7:4];
    e        = '0;
    e.alu    = 4'hF;
    e.mux    = 2'd3;
    e.pc     = 2'd1;
    e.dec    = 2'd1;
    if (op == 4'h0 || (op != 4'h4 && op != 4'h8 && op != 4'hC && alu_of.exists(int'(op)))) begin
      if (op == 4'h0 && !alu_of.exists(int'(ox))) begin
        e.cycles  = 8'd3;
        e.illegal = 1'b1;
        e.alu     = 4'h0;
        e.mux     = 2'd0;
      end else begin
        a        = (op == 4'h0) ? alu_of[int'(ox)] : alu_of[int'(op)];
        e.alu    = a[3:0];
        e.mux    = (op == 4'h0) ? 2'd0 : 2'd1;
        e.cycles = (a == 6) ? 8'd3 : 8'd4;
        e.reg_wr = (a == 6) ? 2'd0 : 2'd1;
      end
    end else if (op == 4'h4 && ox == 4'h0) begin
      e.cycles = 8'(3 + waits);
      e.rd     = 8'(waits + 1);
      e.reg_wr = 2'd1;
      e.wb_sel = 2'd1;
    end else if (op == 4'h4 && ox == 4'h4) begin
      e.cycles = 8'(3 + waits);
      e.wr     = 8'(waits + 1);
    end else if (op == 4'h8) begin
      e.cycles = 8'd4;
      e.alu    = 4'h0;
      e.mux    = 2'd0;
      e.shift  = 1'b1;
      e.regimm = ~ox[2];
      e.reg_wr = 2'd1;
    end else if (op == 4'hC) begin
      taken    = (cond == 4'h0 && fl[1]) || (cond == 4'h1 && !fl[1]) || (cond == 4'hE);
      e.cycles = 8'd3;
      if (taken) begin
        e.pc     = 2'd2;
        e.pc_mux = 2'd1;
      end
    end else begin
      e.cycles  = 8'd2;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic finish_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 200; i++) begin
      if (bus.irEn && !reset) return;
      @(posedge clk);
      #1;
    end
    checks++;
    $display("FAIL fetch_timeout: got no irEn within 200 cycles, expected a FETCH");
    finish_run();
  endtask

  task automatic issue(input logic [15:0] instr, input logic [4:0] fl, input int waits);
    txn_t t;
    wait_fetch();
    bus.instruction = instr;
    bus.flags       = fl;
    waits_cur       = waits;
    t.instr         = instr;
    t.rec           = model(instr, fl, waits);
    exp_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acknowledges after waits_cur low cycles of a request.
  initial begin : responder
    int wcnt;
    wcnt         = 0;
    bus.memReady = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset && (bus.memRead || bus.memWrite)) begin
        bus.memReady = (wcnt >= waits_cur);
        wcnt++;
      end else begin
        bus.memReady = 1'b0;
        wcnt         = 0;
      end
    end
  end

  initial begin : monitor
    rec_t acc;
    txn_t t;
    bit   active;
    acc    = '0;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
        continue;
      end
      if (bus.irEn) begin
        acc     = '0;
        acc.alu = 4'hF;
        acc.mux = 2'd3;
        active  = 1'b1;
      end
      if (active) begin
        acc.cycles = acc.cycles + 8'd1;
        if (bus.srcRegEn && bus.dstRegEn && bus.immRegEn && bus.signEn) acc.dec = acc.dec + 2'd1;
        if (bus.regFileEn) begin
          acc.reg_wr = acc.reg_wr + 2'd1;
          acc.wb_sel = acc.wb_sel | bus.regFileResultCont;
        end
        if (bus.memRead)  acc.rd = acc.rd + 8'd1;
        if (bus.memWrite) acc.wr = acc.wr + 8'd1;
        if (bus.pcRegEn) begin
          acc.pc = acc.pc + 2'd1;
          if (!bus.irEn) acc.pc_mux = acc.pc_mux | bus.mux4En;
        end
        if (bus.resultRegEn) begin
          acc.alu = bus.aluControl;
          acc.mux = bus.mux4En;
        end
        if (bus.shiftALUMuxEn) acc.shift = 1'b1;
        if (bus.regImmMuxEn)   acc.regimm = 1'b1;
        if (bus.instrDone || bus.illegal) begin
          acc.illegal = bus.illegal;
          active      = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_retire: got retire record %h, expected no retirement", acc);
          end else begin
            t = exp_q.pop_front();
            txn_n++;
            $display("txn %0d instr=%h cycles=%0d got=%h exp=%h", txn_n, t.instr, acc.cycles, acc, t.rec);
            check($sformatf("txn%0d_instr_%h", txn_n, t.instr), 64'(acc), 64'(t.rec));
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [15:0] ins;
    int          sel;
    alu_of[5]  = 0;
    alu_of[9]  = 1;
    alu_of[11] = 6;
    alu_of[1]  = 2;
    alu_of[2]  = 3;
    alu_of[3]  = 4;
    alu_of[13] = 5;

    reset           = 1'b1;
    bus.instruction = 16'h4200;
    bus.flags       = 5'h1F;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'(outs()), 64'd0);
    reset = 1'b0;
    #1;
    check("first_fetch", 64'({bus.irEn, bus.pcRegEn, bus.mux4En, bus.aluControl}), 64'({1'b1, 1'b1, 2'd2, 4'd0}));

    issue(16'h0152, 5'b00000, 0);
    issue(16'h5305, 5'b00000, 0);
    issue(16'h4200, 5'b00000, 3);
    issue(16'hC005, 5'b00010, 0);
    issue(16'hC005, 5'b00000, 0);
    issue(16'hF000, 5'b00000, 0);
    issue(16'h4240, 5'b00000, 2);
    issue(16'h01B2, 5'b00000, 0);
    issue(16'h8040, 5'b00000, 0);
    issue(16'h8000, 5'b00000, 0);
    issue(16'h0172, 5'b00000, 0);
    issue(16'hCE00, 5'b00000, 0);

    for (int n = 0; n < 300; n++) begin
      ins = 16'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: begin
          ins[15:12] = 4'h4;
          ins[7:4]   = (sel == 0) ? 4'h0 : 4'h4;
        end
        2: ins[15:12] = 4'h4;
        3, 4: begin
          ins[15:12] = 4'hC;
          ins[11:8]  = conds[$urandom_range(0, 3)];
        end
        5: begin
          ins[15:12] = 4'h0;
          ins[7:4]   = codes[$urandom_range(0, 6)];
        end
        6: ins[15:12] = codes[$urandom_range(0, 6)];
        7: ins[15:12] = 4'h8;
        default: ;
      endcase
      issue(ins, 5'($urandom), int'($urandom_range(0, 4)));
    end

    wait_fetch();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset while a load is stalled on memReady.
    bus.instruction = 16'h4200;
    waits_cur       = 1000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.memRead) break;
    end
    check("load_stalled", 64'(bus.memRead), 64'd1);
    reset = 1'b1;
    #1;
    check("reset_midload_outputs", 64'(outs()), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset_midload_fetch", 64'({bus.irEn, bus.memRead, bus.regFileEn}), 64'(3'b100));
    @(posedge clk);
    #1;
    finish_run();
  end

endmodule
